// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencer for a multi-cycle MIPS-subset datapath.
// Each instruction moves through FETCH, DECODE, and then an execute, memory
// and write-back path that depends on its opcode. The FSM waits on a
// variable-latency memory and counts retired instructions.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   start_i                 run enable, sampled in IDLE and in retire/illegal cycles
//   op_i                    opcode field IR[31:26]
//   zero_i                  ALU zero flag, used by beq
//   mem_ready_i             memory access completes this cycle
//   mem_read_o/mem_write_o  memory requests
//   iord_o                  memory address select (0 PC, 1 ALUOut)
//   ir_write_o, pc_write_o  IR / PC load enables
//   pc_src_o                PC source (00 ALU, 01 ALUOut, 10 jump target)
//   alu_src_a_o/_b_o        ALU operand selects
//   alu_op_o                00 add, 01 sub, 10 funct
//   reg_dst_o, mem_to_reg_o, reg_write_o  register file write controls
//   state_o                 current state code
//   retire_o, illegal_o     single-cycle event pulses
//   retired_cnt_o           retired-instruction counter (wraps)
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       op_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic [3:0]       state_o,
    output logic             retire_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_I_EXEC    = 4'd11,
        S_I_WB      = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        illegal_o    = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 computed by the ALU while the instruction is read;
                // IR and PC only load once memory delivers.
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut speculatively.
                alu_src_b_o = 2'b11;
                case (op_i)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    default: begin
                        illegal_o = 1'b1;
                        state_d   = start_i ? S_FETCH : S_IDLE;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (op_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                retire       = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                retire      = mem_ready_i;
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                retire      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b01;
                pc_src_o    = 2'b01;
                pc_write_o  = zero_i;
                retire      = 1'b1;
            end
            S_JUMP: begin
                pc_src_o   = 2'b10;
                pc_write_o = 1'b1;
                retire     = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Every retiring state shares the same exit: continue or park.
        if (retire) state_d = start_i ? S_FETCH : S_IDLE;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (retire) cnt_d = cnt_q + CNT_W'(1);
    end

    assign retire_o      = retire;
    assign state_o       = state_q;
    assign retired_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [5:0] op_i;
    logic       zero_i;
    logic       mem_ready_i;

    logic        mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0]  pc_src_o, alu_src_b_o, alu_op_o;
    logic        alu_src_a_o, reg_dst_o, mem_to_reg_o, reg_write_o;
    logic [3:0]  state_o;
    logic        retire_o, illegal_o;
    logic [31:0] retired_cnt_o;

    logic        b_mem_read, b_mem_write, b_iord, b_ir_write, b_pc_write;
    logic [1:0]  b_pc_src, b_alu_src_b, b_alu_op;
    logic        b_alu_src_a, b_reg_dst, b_mem_to_reg, b_reg_write;
    logic [3:0]  b_state;
    logic        b_retire, b_illegal;
    logic [1:0]  b_cnt;

    multicycle_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .iord_o(iord_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
        .state_o(state_o), .retire_o(retire_o), .illegal_o(illegal_o),
        .retired_cnt_o(retired_cnt_o)
    );

    // Narrow-counter instance sharing the same stimulus, for the wrap check.
    multicycle_ctrl #(.CNT_W(2)) dut_w2 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .mem_read_o(b_mem_read), .mem_write_o(b_mem_write), .iord_o(b_iord),
        .ir_write_o(b_ir_write), .pc_write_o(b_pc_write), .pc_src_o(b_pc_src),
        .alu_src_a_o(b_alu_src_a), .alu_src_b_o(b_alu_src_b), .alu_op_o(b_alu_op),
        .reg_dst_o(b_reg_dst), .mem_to_reg_o(b_mem_to_reg), .reg_write_o(b_reg_write),
        .state_o(b_state), .retire_o(b_retire), .illegal_o(b_illegal),
        .retired_cnt_o(b_cnt)
    );

    always #5 clk_i = ~clk_i;

    // Bundle: mr mw io ir pw _ pc_src _ src_a _ src_b _ alu_op _ rd mt rw _ ret ill
    logic [16:0] ctrl;
    assign ctrl = {mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
                   pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                   reg_dst_o, mem_to_reg_o, reg_write_o, retire_o, illegal_o};

    localparam logic [16:0] C_IDLE    = 17'b00000_00_0_00_00_000_00;
    localparam logic [16:0] C_FETCH_R = 17'b10011_00_0_01_00_000_00;
    localparam logic [16:0] C_FETCH_W = 17'b10000_00_0_01_00_000_00;
    localparam logic [16:0] C_DEC     = 17'b00000_00_0_11_00_000_00;
    localparam logic [16:0] C_DEC_ILL = 17'b00000_00_0_11_00_000_01;
    localparam logic [16:0] C_MADDR   = 17'b00000_00_1_10_00_000_00;
    localparam logic [16:0] C_MREAD   = 17'b10100_00_0_00_00_000_00;
    localparam logic [16:0] C_MEMWB   = 17'b00000_00_0_00_00_011_10;
    localparam logic [16:0] C_MWR_W   = 17'b01100_00_0_00_00_000_00;
    localparam logic [16:0] C_MWR_R   = 17'b01100_00_0_00_00_000_10;
    localparam logic [16:0] C_REXEC   = 17'b00000_00_1_00_10_000_00;
    localparam logic [16:0] C_RWB     = 17'b00000_00_0_00_00_101_10;
    localparam logic [16:0] C_BR_T    = 17'b00001_01_1_00_01_000_10;
    localparam logic [16:0] C_BR_N    = 17'b00000_01_1_00_01_000_10;
    localparam logic [16:0] C_JUMP    = 17'b00001_10_0_00_00_000_10;
    localparam logic [16:0] C_IEXEC   = 17'b00000_00_1_10_00_000_00;
    localparam logic [16:0] C_IWB     = 17'b00000_00_0_00_00_001_10;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    int n_cmp = 0;
    int n_err = 0;

    task automatic drive(input logic [5:0] op, input logic rdy, input logic st, input logic z);
        op_i        = op;
        mem_ready_i = rdy;
        start_i     = st;
        zero_i      = z;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(OP_R, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(OP_R, 1'b1, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if (state_o !== 4'd0) begin
            $display("FAIL reset_state: got %0d, want 0", state_o); n_err++;
        end
        n_cmp++;
        if (ctrl !== C_IDLE) begin
            $display("FAIL reset_ctrl: got %b, want %b", ctrl, C_IDLE); n_err++;
        end
        n_cmp++;
        if (retired_cnt_o !== 32'd0 || b_cnt !== 2'd0) begin
            $display("FAIL reset_cnt: got %0d/%0d, want 0/0", retired_cnt_o, b_cnt); n_err++;
        end
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        drive(OP_R, 1'b1, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        n_cmp++;
        if (state_o !== 4'd0) begin
            $display("FAIL idle_hold: got %0d, want 0", state_o); n_err++;
        end
    endtask

    task automatic test_r_loop();
        logic [3:0]  es [4];
        logic [16:0] ec [4];
        es = '{4'd1, 4'd2, 4'd7, 4'd8};
        ec = '{C_FETCH_R, C_DEC, C_REXEC, C_RWB};
        do_reset();
        drive(OP_R, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            @(negedge clk_i);
            n_cmp++;
            if (state_o !== es[i%4] || ctrl !== ec[i%4] || retired_cnt_o !== 32'(i/4)) begin
                $display("FAIL r_loop[%0d]: state=%0d ctrl=%b cnt=%0d, want state=%0d ctrl=%b cnt=%0d",
                         i, state_o, ctrl, retired_cnt_o, es[i%4], ec[i%4], i/4);
                n_err++;
            end
        end
        next_cycle();
        n_cmp++;
        if (state_o !== 4'd1 || retired_cnt_o !== 32'd3) begin
            $display("FAIL r_loop_end: state=%0d cnt=%0d, want 1/3", state_o, retired_cnt_o); n_err++;
        end
    endtask

    task automatic test_lw_wait();
        logic        rdy [9];
        logic [3:0]  es  [9];
        logic [16:0] ec  [9];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        es  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd0};
        ec  = '{C_FETCH_R, C_DEC, C_MADDR, C_MREAD, C_MREAD, C_MREAD, C_MREAD, C_MEMWB, C_IDLE};
        do_reset();
        drive(OP_LW, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            drive(OP_LW, rdy[i], 1'b0, 1'b0);
            @(negedge clk_i);
            n_cmp++;
            if (state_o !== es[i] || ctrl !== ec[i]) begin
                $display("FAIL lw_wait[%0d]: state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
                n_err++;
            end
        end
        n_cmp++;
        if (retired_cnt_o !== 32'd1) begin
            $display("FAIL lw_cnt: got %0d, want 1", retired_cnt_o); n_err++;
        end
    endtask

    task automatic test_beq();
        logic        z  [7];
        logic [3:0]  es [7];
        logic [16:0] ec [7];
        z  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        es = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd9, 4'd1};
        ec = '{C_FETCH_R, C_DEC, C_BR_T, C_FETCH_R, C_DEC, C_BR_N, C_FETCH_R};
        do_reset();
        drive(OP_BEQ, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            drive(OP_BEQ, 1'b1, 1'b1, z[i]);
            @(negedge clk_i);
            n_cmp++;
            if (state_o !== es[i] || ctrl !== ec[i]) begin
                $display("FAIL beq[%0d]: state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
                n_err++;
            end
        end
        n_cmp++;
        if (retired_cnt_o !== 32'd2) begin
            $display("FAIL beq_cnt: got %0d, want 2", retired_cnt_o); n_err++;
        end
    endtask

    task automatic test_illegal();
        logic        st [5];
        logic [3:0]  es [5];
        logic [16:0] ec [5];
        st = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        es = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd0};
        ec = '{C_FETCH_R, C_DEC_ILL, C_FETCH_R, C_DEC_ILL, C_IDLE};
        do_reset();
        drive(OP_ILL, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            drive(OP_ILL, 1'b1, st[i], 1'b0);
            @(negedge clk_i);
            n_cmp++;
            if (state_o !== es[i] || ctrl !== ec[i]) begin
                $display("FAIL illegal[%0d]: state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
                n_err++;
            end
        end
        n_cmp++;
        if (retired_cnt_o !== 32'd0) begin
            $display("FAIL illegal_cnt: got %0d, want 0", retired_cnt_o); n_err++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op  [14];
        logic        rdy [14];
        logic        st  [14];
        logic [3:0]  es  [14];
        logic [16:0] ec  [14];
        op  = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_J, OP_J, OP_J,
                OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        st  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        es  = '{4'd1, 4'd2, 4'd11, 4'd12, 4'd1, 4'd2, 4'd10,
                4'd1, 4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd0};
        ec  = '{C_FETCH_R, C_DEC, C_IEXEC, C_IWB, C_FETCH_R, C_DEC, C_JUMP,
                C_FETCH_W, C_FETCH_R, C_DEC, C_MADDR, C_MWR_W, C_MWR_R, C_IDLE};
        do_reset();
        drive(OP_ADDI, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            next_cycle();
            drive(op[i], rdy[i], st[i], 1'b0);
            @(negedge clk_i);
            n_cmp++;
            if (state_o !== es[i] || ctrl !== ec[i]) begin
                $display("FAIL b2b[%0d]: state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
                n_err++;
            end
        end
        n_cmp++;
        if (retired_cnt_o !== 32'd3) begin
            $display("FAIL b2b_cnt: got %0d, want 3", retired_cnt_o); n_err++;
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        drive(OP_R, 1'b1, 1'b1, 1'b0);
        repeat (4) next_cycle();
        drive(OP_SW, 1'b1, 1'b1, 1'b0);
        repeat (3) next_cycle();
        drive(OP_SW, 1'b0, 1'b1, 1'b0);
        repeat (2) next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if (state_o !== 4'd6 || mem_write_o !== 1'b1 || retired_cnt_o !== 32'd1) begin
            $display("FAIL pre_rst: state=%0d mw=%b cnt=%0d, want 6/1/1",
                     state_o, mem_write_o, retired_cnt_o);
            n_err++;
        end
        #1 rst_i = 1'b1;
        #1;
        n_cmp++;
        if (state_o !== 4'd0 || ctrl !== C_IDLE) begin
            $display("FAIL mid_rst_state: state=%0d ctrl=%b, want 0/%b", state_o, ctrl, C_IDLE); n_err++;
        end
        n_cmp++;
        if (retired_cnt_o !== 32'd0) begin
            $display("FAIL mid_rst_cnt: got %0d, want 0", retired_cnt_o); n_err++;
        end
        next_cycle();
        rst_i = 1'b0;
        drive(OP_SW, 1'b1, 1'b0, 1'b0);
        repeat (3) next_cycle();
        n_cmp++;
        if (state_o !== 4'd0) begin
            $display("FAIL rst_no_start: state=%0d, want 0", state_o); n_err++;
        end
        start_i = 1'b1;
        next_cycle();
        n_cmp++;
        if (state_o !== 4'd1) begin
            $display("FAIL rst_restart: state=%0d, want 1", state_o); n_err++;
        end
    endtask

    task automatic test_wrap();
        logic [1:0] w2 [5];
        w2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        drive(OP_R, 1'b1, 1'b1, 1'b0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            repeat (4) next_cycle();
            n_cmp++;
            if (b_cnt !== w2[k] || retired_cnt_o !== 32'(k + 1) || state_o !== 4'd1) begin
                $display("FAIL wrap[%0d]: cnt2=%0d cnt32=%0d state=%0d, want %0d/%0d/1",
                         k, b_cnt, retired_cnt_o, state_o, w2[k], k + 1);
                n_err++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_loop();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_reset_mid_write();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
